// File: rtl/seq_divider8_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seq_divider8_pkg
// Brief   : Shared constants and types for the sequential 8-bit divider.
// Revision: 1.0
// ============================================================================
package seq_divider8_pkg;

    localparam int W    = 8;
    localparam int ITER = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef logic [2:0] cnt_t;

endpackage : seq_divider8_pkg
`default_nettype wire

// File: rtl/seq_divider8_if.sv
`default_nettype none
// ============================================================================
// Module  : seq_divider8_if
// Brief   : Start/done coprocessor handshake and result bus of the divider.
// Revision: 1.0
// ============================================================================
interface seq_divider8_if;

    logic                              start;
    logic [seq_divider8_pkg::W-1:0]    a;
    logic [seq_divider8_pkg::W-1:0]    b;
    logic                              busy;
    logic                              done;
    logic [seq_divider8_pkg::W-1:0]    q;
    logic [seq_divider8_pkg::W-1:0]    r;
    logic                              div_by_zero;

    modport master (
        output start, a, b,
        input  busy, done, q, r, div_by_zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, q, r, div_by_zero
    );

endinterface : seq_divider8_if
`default_nettype wire

// File: rtl/fulladder8.sv
`default_nettype none
// ============================================================================
// Module  : fulladder8
// Brief   : 8-bit adder with carry in and carry out.
// Revision: 1.0
// ============================================================================
module fulladder8 (
    output logic [7:0] sum,
    output logic       cout,
    input  wire  [7:0] a,
    input  wire  [7:0] b,
    input  wire        cin
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {8'd0, cin};

endmodule : fulladder8
`default_nettype wire

// File: rtl/seq_divider8_step.sv
`default_nettype none
// ============================================================================
// Module  : div8_step
// Brief   : One combinational restoring-division iteration on a 9-bit remainder.
// Revision: 1.0
// ============================================================================
module div8_step
    import seq_divider8_pkg::*;
(
    input  wire  [W:0]   i_p,
    input  wire          i_dividend_msb,
    input  wire  [W-1:0] i_b,
    output logic [W:0]   o_p_next,
    output logic         o_qbit
);

    logic [W:0]   w_p_shift;
    logic [W-1:0] w_diff;
    logic         w_ge;
    logic         w_unused_p_msb;

    // The running remainder is always below b, so its 9th bit carries nothing.
    assign w_unused_p_msb = i_p[W];
    assign w_p_shift      = {i_p[W-1:0], i_dividend_msb};

    subtract8 u_sub (
        .a    (w_p_shift[W-1:0]),
        .b    (i_b),
        .diff (w_diff)
    );

    // A set 9th bit means P' >= 256 > b; otherwise the low byte decides.
    assign w_ge = w_p_shift[W] | (w_p_shift[W-1:0] >= i_b);

    always_comb begin
        o_p_next = w_p_shift;
        o_qbit   = 1'b0;
        if (w_ge) begin
            // P' - b < b <= 255, so the difference fits in the low byte.
            o_p_next = {1'b0, w_diff};
            o_qbit   = 1'b1;
        end
    end

endmodule : div8_step
`default_nettype wire

// File: rtl/shift_left8.sv
`default_nettype none
// ============================================================================
// Module  : shift_left8
// Brief   : Logical left shift by one, zero fill.
// Revision: 1.0
// ============================================================================
module shift_left8 (
    input  wire  [7:0] in,
    output logic [7:0] out
);

    // The MSB falls off the end by design.
    logic w_unused_msb;
    assign w_unused_msb = in[7];

    assign out = {in[6:0], 1'b0};

endmodule : shift_left8
`default_nettype wire

// File: rtl/subtract8.sv
`default_nettype none
// ============================================================================
// Module  : subtract8
// Brief   : 8-bit modulo-256 subtractor.
// Revision: 1.0
// ============================================================================
module subtract8 (
    input  wire  [7:0] a,
    input  wire  [7:0] b,
    output logic [7:0] diff
);

    assign diff = a - b;

endmodule : subtract8
`default_nettype wire

// File: rtl/seq_divider8.sv
`default_nettype none
// ============================================================================
// Module  : seq_divider8
// Brief   : Multi-cycle 8-bit unsigned restoring divider, one quotient bit/clock.
// Revision: 1.0
// ============================================================================
module seq_divider8
    import seq_divider8_pkg::*;
(
    input  wire              clk,
    input  wire              rst,
    seq_divider8_if.slave    bus
);

    state_t       r_state;
    state_t       w_state_next;
    logic         w_accept;
    logic         w_last;

    logic [W-1:0] r_dividend;
    logic [W-1:0] r_divisor;
    logic [W:0]   r_p;
    logic [W-1:0] r_quot;
    cnt_t         r_cnt;
    logic         r_done;
    logic [W-1:0] r_q;
    logic [W-1:0] r_r;
    logic         r_dbz;

    logic [W-1:0] w_dividend_shl;
    logic [W:0]   w_p_next;
    logic         w_qbit;
    logic [W-1:0] w_cnt_sum;
    logic         w_cnt_cout;
    logic [W-1:0] w_quot_next;
    logic         w_unused_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_next = RUN;
                    w_accept     = 1'b1;
                end
            end
            RUN: begin
                if (r_cnt == cnt_t'(ITER - 1)) begin
                    w_state_next = IDLE;
                    w_last       = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    shift_left8 u_shl (
        .in  (r_dividend),
        .out (w_dividend_shl)
    );

    div8_step u_step (
        .i_p            (r_p),
        .i_dividend_msb (r_dividend[W-1]),
        .i_b            (r_divisor),
        .o_p_next       (w_p_next),
        .o_qbit         (w_qbit)
    );

    fulladder8 u_cnt_inc (
        .sum  (w_cnt_sum),
        .cout (w_cnt_cout),
        .a    ({5'd0, r_cnt}),
        .b    (8'd1),
        .cin  (1'b0)
    );

    // The 3-bit counter only needs the low bits of the adder.
    assign w_unused_cnt = w_cnt_cout | (|w_cnt_sum[W-1:3]);
    assign w_quot_next  = {r_quot[W-2:0], w_qbit};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dividend <= '0;
            r_divisor  <= '0;
            r_p        <= '0;
            r_quot     <= '0;
            r_cnt      <= '0;
            r_done     <= 1'b0;
            r_q        <= '0;
            r_r        <= '0;
            r_dbz      <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_dividend <= bus.a;
                r_divisor  <= bus.b;
                r_p        <= '0;
                r_quot     <= '0;
                r_cnt      <= '0;
                r_dbz      <= 1'b0;
            end else if (r_state == RUN) begin
                r_dividend <= w_dividend_shl;
                r_p        <= w_p_next;
                r_quot     <= w_quot_next;
                r_cnt      <= w_cnt_sum[2:0];
                // Results update only on the final edge so the old ones stay visible.
                if (w_last) begin
                    r_q   <= w_quot_next;
                    r_r   <= w_p_next[W-1:0];
                    r_dbz <= (r_divisor == '0);
                end
            end
        end
    end

    assign bus.busy        = (r_state == RUN);
    assign bus.done        = r_done;
    assign bus.q           = r_q;
    assign bus.r           = r_r;
    assign bus.div_by_zero = r_dbz;

endmodule : seq_divider8
`default_nettype wire

// File: tb/tb_seq_divider8.sv
`default_nettype none
// ============================================================================
// Module  : tb_seq_divider8
// Brief   : Scoreboard bench for seq_divider8 with directed and random divisions.
// Revision: 1.0
// ============================================================================
module tb_seq_divider8;

    typedef struct {
        logic [7:0]  q;
        logic [7:0]  r;
        logic        dbz;
        int unsigned cyc;
    } exp_t;

    logic        clk;
    logic        rst;
    int unsigned cyc;
    int unsigned n_vec;
    int unsigned n_miss;
    logic        prev_done;
    exp_t        sb[$];

    seq_divider8_if bus ();

    seq_divider8 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one start pulse from a negedge; the expected result is queued on the accept edge.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        e.q   = (b == 0) ? 8'hFF : 8'(a / b);
        e.r   = (b == 0) ? a     : 8'(a % b);
        e.dbz = (b == 0);
        e.cyc = cyc + 8;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = $urandom_range(0, 255);
        bus.b     = $urandom_range(0, 255);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done) break;
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (prev_done) chk("done_width", {31'd0, bus.done}, 32'd0);
            if (bus.done) begin
                chk("busy_with_done", {31'd0, bus.busy}, 32'd0);
                if (sb.size() == 0) begin
                    chk("unexpected_done", {31'd0, bus.done}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("q",       {24'd0, bus.q}, {24'd0, e.q});
                    chk("r",       {24'd0, bus.r}, {24'd0, e.r});
                    chk("dbz",     {31'd0, bus.div_by_zero}, {31'd0, e.dbz});
                    chk("latency", cyc, e.cyc);
                end
            end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
                chk("done_timeout", {31'd0, bus.done}, 32'd1);
                void'(sb.pop_front());
            end
        end
        prev_done = bus.done;
    end

    initial begin
        n_vec     = 0;
        n_miss    = 0;
        prev_done = 1'b0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = 8'd0;
        bus.b     = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_q",    {24'd0, bus.q}, 32'd0);
        chk("rst_r",    {24'd0, bus.r}, 32'd0);
        chk("rst_dbz",  {31'd0, bus.div_by_zero}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_op(8'd100, 8'd7);
        chk("busy_after_accept", {31'd0, bus.busy}, 32'd1);
        wait_done();
        do_op(8'd255, 8'd200); wait_done();
        do_op(8'd255, 8'd1);   wait_done();
        do_op(8'd5,   8'd9);   wait_done();
        do_op(8'd200, 8'd0);   wait_done();

        // Start while busy is ignored; the old result stays visible during the run.
        do_op(8'd100, 8'd7);
        repeat (2) @(negedge clk);
        chk("hold_q",   {24'd0, bus.q}, 32'd255);
        chk("hold_r",   {24'd0, bus.r}, 32'd200);
        chk("dbz_clr",  {31'd0, bus.div_by_zero}, 32'd0);
        bus.start = 1'b1;
        bus.a     = 8'd50;
        bus.b     = 8'd3;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();
        do_op(8'd37, 8'd5);
        wait_done();

        // Reset on the 4th iteration edge discards the run.
        do_op(8'd100, 8'd7);
        repeat (3) @(negedge clk);
        sb.delete();
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        chk("midrst_done", {31'd0, bus.done}, 32'd0);
        chk("midrst_q",    {24'd0, bus.q}, 32'd0);
        chk("midrst_r",    {24'd0, bus.r}, 32'd0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        do_op(8'd100, 8'd7);
        wait_done();

        for (int i = 0; i < 1000; i++) begin
            do_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            wait_done();
        end

        repeat (12) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_seq_divider8
`default_nettype wire
